// File: rtl/jam_pkg.sv
// Shared types and width helpers for the parametrised job-assignment engine.
package jam_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ACC,
        S_CMP,
        S_DONE
    } state_t;

    // N <= 2**idxw, so N*(2**cw - 1) always fits and stays below the all-ones min seed.
    function automatic int sum_w(input int cw, input int idxw);
        return cw + idxw;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
        return (v >= maxv) ? maxv : v + 32'd1;
    endfunction

endpackage

// File: rtl/jam_nextperm.sv
// Combinational lexicographic next-permutation; last_o flags the final (descending) order.
module jam_nextperm #(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0][IDXW-1:0] perm_i,
    output logic [N-1:0][IDXW-1:0] perm_o,
    output logic                   last_o
);
    int                     piv;
    int                     sw;
    logic [IDXW-1:0]        pv;
    logic [IDXW-1:0]        sv;
    logic [N-1:0][IDXW-1:0] swp;

    always_comb begin
        piv    = 0;
        last_o = 1'b1;
        for (int i = 0; i < N - 1; i++) begin
            if (perm_i[i] < perm_i[i+1]) begin
                piv    = i;
                last_o = 1'b0;
            end
        end

        pv = '0;
        for (int i = 0; i < N; i++) begin
            if (i == piv) pv = perm_i[i];
        end

        sw = piv + 1;
        for (int j = 0; j < N; j++) begin
            if (j > piv && perm_i[j] > pv) sw = j;
        end

        sv = '0;
        for (int i = 0; i < N; i++) begin
            if (i == sw) sv = perm_i[i];
        end

        for (int k = 0; k < N; k++) begin
            if (k == piv)     swp[k] = sv;
            else if (k == sw) swp[k] = pv;
            else              swp[k] = perm_i[k];
        end

        // Tail after the pivot is reversed: position k takes element N+piv-k.
        perm_o = swp;
        for (int k = 0; k < N; k++) begin
            for (int m = 0; m < N; m++) begin
                if (k > piv && m == N + piv - k) perm_o[k] = swp[m];
            end
        end
    end

endmodule

// File: rtl/jam_param.sv
// Exhaustive N x N assignment search over an external 1-cycle-latency cost ROM.
// state | meaning
// IDLE  | wait for Start
// FETCH | drive W/J for k=0..N-1, accumulate read k-1
// ACC   | accumulate the last read
// CMP   | update min/count, step permutation
// DONE  | publish results, Valid pulse
module jam_param
    import jam_pkg::*;
#(
    parameter int N    = 8,
    parameter int CW   = 7,
    parameter int IDXW = $clog2(N),
    parameter int MCW  = 16
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               Start,
    output logic               Busy,
    output logic [IDXW-1:0]    W,
    output logic [IDXW-1:0]    J,
    input  logic [CW-1:0]      Cost,
    output logic [CW+IDXW-1:0] MinCost,
    output logic [MCW-1:0]     MatchCount,
    output logic               Valid
);
    localparam int              SW      = sum_w(CW, IDXW);
    localparam logic [31:0]     CNT_MAX = 32'((64'd1 << MCW) - 64'd1);
    localparam logic [IDXW-1:0] K_LAST  = IDXW'(N - 1);

    state_t                 state_q, state_d;
    logic [IDXW-1:0]        k_q, k_d;
    logic [N-1:0][IDXW-1:0] perm_q, perm_d, perm_nxt;
    logic                   perm_last;
    logic [SW-1:0]          sum_q, sum_d;
    logic [SW-1:0]          min_q, min_d;
    logic [MCW-1:0]         cnt_q, cnt_d;
    logic [IDXW-1:0]        w_q, w_d, j_q, j_d;
    logic                   busy_q, busy_d, valid_q, valid_d;
    logic [SW-1:0]          mincost_q, mincost_d;
    logic [MCW-1:0]         matchcnt_q, matchcnt_d;

    jam_nextperm #(.N(N), .IDXW(IDXW)) u_nextperm (
        .perm_i (perm_q),
        .perm_o (perm_nxt),
        .last_o (perm_last)
    );

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        perm_d     = perm_q;
        sum_d      = sum_q;
        min_d      = min_q;
        cnt_d      = cnt_q;
        w_d        = '0;
        j_d        = '0;
        valid_d    = 1'b0;
        mincost_d  = mincost_q;
        matchcnt_d = matchcnt_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    for (int k = 0; k < N; k++) perm_d[k] = IDXW'(k);
                    sum_d   = '0;
                    min_d   = '1;
                    cnt_d   = '0;
                    k_d     = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (k_q != '0) sum_d = sum_q + SW'(Cost);
                if (k_q == K_LAST) begin
                    state_d = S_ACC;
                end else begin
                    k_d = k_q + 1'b1;
                    w_d = k_q + 1'b1;
                    j_d = perm_q[k_q + 1'b1];
                end
            end
            S_ACC: begin
                sum_d   = sum_q + SW'(Cost);
                state_d = S_CMP;
            end
            S_CMP: begin
                if (sum_q < min_q) begin
                    min_d = sum_q;
                    cnt_d = MCW'(1);
                end else if (sum_q == min_q) begin
                    cnt_d = MCW'(sat_inc(32'(cnt_q), CNT_MAX));
                end
                sum_d  = '0;
                k_d    = '0;
                perm_d = perm_nxt;
                if (perm_last) begin
                    state_d    = S_DONE;
                    valid_d    = 1'b1;
                    mincost_d  = min_d;
                    matchcnt_d = cnt_d;
                end else begin
                    state_d = S_FETCH;
                    j_d     = perm_nxt[0];
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Busy rises one cycle into the run and drops on the Valid cycle.
        busy_d = (state_q inside {S_FETCH, S_ACC, S_CMP}) && (state_d != S_DONE);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            perm_q     <= '0;
            sum_q      <= '0;
            min_q      <= '0;
            cnt_q      <= '0;
            w_q        <= '0;
            j_q        <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            mincost_q  <= '0;
            matchcnt_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            perm_q     <= perm_d;
            sum_q      <= sum_d;
            min_q      <= min_d;
            cnt_q      <= cnt_d;
            w_q        <= w_d;
            j_q        <= j_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            mincost_q  <= mincost_d;
            matchcnt_q <= matchcnt_d;
        end
    end

    assign Busy       = busy_q;
    assign W          = w_q;
    assign J          = j_q;
    assign MinCost    = mincost_q;
    assign MatchCount = matchcnt_q;
    assign Valid      = valid_q;

endmodule

// File: tb/tb_jam_param.sv
// Directed bench for jam_param at N=2, N=3 and N=4 (MCW=4 for saturation).
module tb_jam_param;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start2, busy2, valid2;
    logic [0:0] w2, j2;
    logic [6:0] cost2;
    logic [7:0] min2;
    logic [15:0] cnt2;

    logic       start3, busy3, valid3;
    logic [1:0] w3, j3;
    logic [6:0] cost3;
    logic [8:0] min3;
    logic [15:0] cnt3;

    logic       start4, busy4, valid4;
    logic [1:0] w4, j4;
    logic [6:0] cost4;
    logic [8:0] min4;
    logic [3:0] cnt4;

    logic [6:0] rom2 [0:1][0:1];
    logic [6:0] rom3 [0:2][0:2];
    logic [6:0] rom4 [0:3][0:3];

    always @(posedge clk) begin
        cost2 <= rom2[w2][j2];
        cost3 <= rom3[w3][j3];
        cost4 <= rom4[w4][j4];
    end

    jam_param #(.N(2), .CW(7), .MCW(16)) d2 (
        .CLK(clk), .RST_n(rst_n), .Start(start2), .Busy(busy2), .W(w2), .J(j2),
        .Cost(cost2), .MinCost(min2), .MatchCount(cnt2), .Valid(valid2));

    jam_param #(.N(3), .CW(7), .MCW(16)) d3 (
        .CLK(clk), .RST_n(rst_n), .Start(start3), .Busy(busy3), .W(w3), .J(j3),
        .Cost(cost3), .MinCost(min3), .MatchCount(cnt3), .Valid(valid3));

    jam_param #(.N(4), .CW(7), .MCW(4)) d4 (
        .CLK(clk), .RST_n(rst_n), .Start(start4), .Busy(busy4), .W(w4), .J(j4),
        .Cost(cost4), .MinCost(min4), .MatchCount(cnt4), .Valid(valid4));

    int n_checks = 0;
    int n_fail   = 0;

    // Start is driven on a negedge and sampled by the next posedge; returns at the negedge of run cycle 1.
    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 2) start2 = 1'b1;
        if (which == 3) start3 = 1'b1;
        if (which == 4) start4 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        start3 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy2, valid2, w2, j2, min2, cnt2} !== '0) begin
            n_fail++;
            $display("FAIL reset_n2: got busy=%0d valid=%0d w=%0d j=%0d min=%0d cnt=%0d, expected all 0",
                     busy2, valid2, w2, j2, min2, cnt2);
        end
        n_checks++;
        if ({busy3, valid3, w3, j3, min3, cnt3} !== '0) begin
            n_fail++;
            $display("FAIL reset_n3: got busy=%0d valid=%0d w=%0d j=%0d min=%0d cnt=%0d, expected all 0",
                     busy3, valid3, w3, j3, min3, cnt3);
        end
        n_checks++;
        if ({busy4, valid4, w4, j4, min4, cnt4} !== '0) begin
            n_fail++;
            $display("FAIL reset_n4: got busy=%0d valid=%0d w=%0d j=%0d min=%0d cnt=%0d, expected all 0",
                     busy4, valid4, w4, j4, min4, cnt4);
        end
    endtask

    task automatic test_n2_basic();
        int c, nb;
        logic [1:0]  wj [1:8];
        logic [15:0] got_seq;
        rom2[0][0] = 7'd1; rom2[0][1] = 7'd2;
        rom2[1][0] = 7'd3; rom2[1][1] = 7'd4;
        for (int i = 1; i <= 8; i++) wj[i] = 2'b00;
        pulse(2);
        c = 1; nb = 0;
        while (valid2 !== 1'b1 && c < 60) begin
            if (c <= 8) wj[c] = {w2, j2};
            if (busy2) nb++;
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (c != 9) begin n_fail++; $display("FAIL n2_valid_cycle: got %0d, expected 9", c); end
        n_checks++;
        if (nb != 7) begin n_fail++; $display("FAIL n2_busy_len: got %0d, expected 7", nb); end
        n_checks++;
        if (busy2 !== 1'b0) begin n_fail++; $display("FAIL n2_busy_at_valid: got %0d, expected 0", busy2); end
        n_checks++;
        if (min2 !== 8'd5) begin n_fail++; $display("FAIL n2_mincost: got %0d, expected 5", min2); end
        n_checks++;
        if (cnt2 !== 16'd2) begin n_fail++; $display("FAIL n2_matchcount: got %0d, expected 2", cnt2); end
        got_seq = {wj[1], wj[2], wj[3], wj[4], wj[5], wj[6], wj[7], wj[8]};
        n_checks++;
        if (got_seq !== 16'b00_11_00_00_01_10_00_00) begin
            n_fail++;
            $display("FAIL n2_wj_seq: got %b, expected 0011000001100000", got_seq);
        end
        @(negedge clk);
        n_checks++;
        if (valid2 !== 1'b0) begin n_fail++; $display("FAIL n2_valid_pulse: got %0d, expected 0", valid2); end
    endtask

    task automatic test_n3_start_while_busy();
        int c, nb, late_busy;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++)
                rom3[i][k] = (i == k) ? ((i == 2) ? 7'd1 : 7'd5) : 7'd9;
        pulse(3);
        c = 1; nb = 0;
        while (valid3 !== 1'b1 && c < 120) begin
            if (c == 10) start3 = 1'b1;
            if (c == 11) start3 = 1'b0;
            if (busy3) nb++;
            @(negedge clk);
            c++;
        end
        start3 = 1'b0;
        n_checks++;
        if (c != 31) begin n_fail++; $display("FAIL n3_valid_cycle: got %0d, expected 31", c); end
        n_checks++;
        if (nb != 29) begin n_fail++; $display("FAIL n3_busy_len: got %0d, expected 29", nb); end
        n_checks++;
        if (min3 !== 9'd11) begin n_fail++; $display("FAIL n3_mincost: got %0d, expected 11", min3); end
        n_checks++;
        if (cnt3 !== 16'd1) begin n_fail++; $display("FAIL n3_matchcount: got %0d, expected 1", cnt3); end
        late_busy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy3 || valid3) late_busy++;
        end
        n_checks++;
        if (late_busy != 0) begin n_fail++; $display("FAIL n3_no_relaunch: got %0d busy cycles, expected 0", late_busy); end
    endtask

    task automatic test_saturation();
        int c;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 4; k++)
                    rom4[i][k] = (pass == 0) ? 7'd1 : 7'd127;
            pulse(4);
            c = 1;
            while (valid4 !== 1'b1 && c < 300) begin
                @(negedge clk);
                c++;
            end
            n_checks++;
            if (c != 145) begin n_fail++; $display("FAIL sat_valid_cycle[%0d]: got %0d, expected 145", pass, c); end
            n_checks++;
            if (min4 !== ((pass == 0) ? 9'd4 : 9'd508)) begin
                n_fail++;
                $display("FAIL sat_mincost[%0d]: got %0d, expected %0d", pass, min4, (pass == 0) ? 4 : 508);
            end
            n_checks++;
            if (cnt4 !== 4'd15) begin n_fail++; $display("FAIL sat_matchcount[%0d]: got %0d, expected 15", pass, cnt4); end
        end
    endtask

    task automatic test_reset_midrun();
        int c;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                rom4[i][k] = (i + k == 3) ? 7'd1 : 7'd10;
        pulse(4);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy4 !== 1'b1 || w4 !== 2'd2) begin
            n_fail++;
            $display("FAIL midrun_pre: got busy=%0d w=%0d, expected busy=1 w=2", busy4, w4);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy4, valid4, w4, j4, min4, cnt4} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy=%0d valid=%0d w=%0d j=%0d min=%0d cnt=%0d, expected all 0",
                     busy4, valid4, w4, j4, min4, cnt4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse(4);
        c = 1;
        while (valid4 !== 1'b1 && c < 300) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (c != 145) begin n_fail++; $display("FAIL midrun_rerun_cycle: got %0d, expected 145", c); end
        n_checks++;
        if (min4 !== 9'd4) begin n_fail++; $display("FAIL midrun_mincost: got %0d, expected 4", min4); end
        n_checks++;
        if (cnt4 !== 4'd1) begin n_fail++; $display("FAIL midrun_matchcount: got %0d, expected 1", cnt4); end
    endtask

    task automatic test_back_to_back();
        int np, v1, v2;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++)
                rom3[i][k] = (i == k) ? ((i == 2) ? 7'd1 : 7'd5) : 7'd9;
        np = 0; v1 = 0; v2 = 0;
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 75; c++) begin
            if (valid3 === 1'b1) begin
                np++;
                if (np == 1) begin
                    v1 = c;
                    n_checks++;
                    if (min3 !== 9'd11 || cnt3 !== 16'd1) begin
                        n_fail++;
                        $display("FAIL b2b_run1: got min=%0d cnt=%0d, expected 11/1", min3, cnt3);
                    end
                    for (int i = 0; i < 3; i++)
                        for (int k = 0; k < 3; k++)
                            rom3[i][k] = 7'd2;
                end else begin
                    v2 = c;
                    n_checks++;
                    if (min3 !== 9'd6 || cnt3 !== 16'd6) begin
                        n_fail++;
                        $display("FAIL b2b_run2: got min=%0d cnt=%0d, expected 6/6", min3, cnt3);
                    end
                    start3 = 1'b0;
                end
            end
            if (c == 45) begin
                n_checks++;
                if (min3 !== 9'd11 || cnt3 !== 16'd1) begin
                    n_fail++;
                    $display("FAIL b2b_hold: got min=%0d cnt=%0d, expected 11/1", min3, cnt3);
                end
            end
            @(negedge clk);
        end
        start3 = 1'b0;
        n_checks++;
        if (np != 2 || v1 != 31 || v2 != 63) begin
            n_fail++;
            $display("FAIL b2b_pulses: got count=%0d at %0d,%0d, expected 2 at 31,63", np, v1, v2);
        end
        n_checks++;
        if (busy3 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: got busy=%0d, expected 0", busy3); end
    endtask

    initial begin
        rst_n  = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
        start4 = 1'b0;
        for (int i = 0; i < 2; i++) for (int k = 0; k < 2; k++) rom2[i][k] = '0;
        for (int i = 0; i < 3; i++) for (int k = 0; k < 3; k++) rom3[i][k] = '0;
        for (int i = 0; i < 4; i++) for (int k = 0; k < 4; k++) rom4[i][k] = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_n2_basic();
        test_n3_start_while_busy();
        test_saturation();
        test_reset_midrun();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jam_param.md
# jam_param

Parametrised job-assignment engine, the successor to the fixed 8×8 JAM block. It exhaustively enumerates all N! worker→job assignments of an N×N cost table held in an external cost ROM, and reports the minimum total cost plus the number of assignments achieving it. Unlike the fixed block, it adds the following:
- parameters for table size, cost width and match-count width;
- a Start/Busy handshake, so the block can be re-run without reset;
- a saturating match counter.

## Interface
Parameters:
- N, 8, workers = jobs; legal 2..8
- CW, 7, cost entry width
- IDXW, $clog2(N), width of W/J
- MCW, 16, MatchCount width; saturates at 2^MCW−1

Ports:
- CLK  in  1  clock; all flops on rising edge
- RST_n  in  1  reset, asynchronous, active-low
- Start  in  1  run request, sampled only in IDLE
- Busy  out  1  high from the cycle after Start is accepted until Valid
- W  out  IDXW  worker index to cost ROM
- J  out  IDXW  job index to cost ROM
- Cost  in  CW  ROM data for the W/J driven in the previous cycle (1-cycle read latency)
- MinCost  out  CW+IDXW  minimum total cost of the last run
- MatchCount  out  MCW  number of permutations equal to MinCost
- Valid  out  1  one-cycle pulse, results final

## Operation
- States: IDLE → FETCH → ACC → CMP → (FETCH | DONE) → IDLE.
- **IDLE:** on Start=1, load perm = identity (perm[k]=k), clear sum, min=all-ones, count=0, then go to FETCH.
- **FETCH:** N cycles, k=0..N−1. Drive W=k, J=perm[k]. In cycles k≥1, sum += Cost (the read k−1).
- **ACC:** 1 cycle. sum += Cost (the read N−1).
- **CMP:** 1 cycle.
  - If sum<min: min=sum, count=1.
  - Else if sum==min: count=count+1, held at 2^MCW−1 once reached.
  - Clear sum, then compute the next permutation:
    - pivot i = largest i with perm[i]<perm[i+1];
    - swap perm[i] with the rightmost perm[j]>perm[i];
    - reverse perm[i+1..N−1].
  - If a pivot exists, go to FETCH; otherwise go to DONE.
- **DONE:** 1 cycle. MinCost=min, MatchCount=count, Valid=1, Busy=0, then go to IDLE.
- Arithmetic: sum width CW+IDXW; max N·(2^CW−1) fits, no overflow.
- MinCost/MatchCount hold their last values until the next DONE.
- Start while Busy is ignored. Start held high continuously re-launches a run one cycle after each DONE.
- Reset: async clear to IDLE, aborting any run in progress. Partial results are discarded.
- W/J outside FETCH: hold 0.

## Timing
- Reset values: W=0, J=0, Busy=0, Valid=0, MinCost=0, MatchCount=0.
- Each permutation takes N+2 cycles.
- Valid rises at the edge N!·(N+2) cycles after the edge that samples Start. Examples: N=2 → 8 cycles; N=8 → 403200 cycles.
- Busy is high for exactly N!·(N+2)−1 cycles, then low in the Valid cycle.
- All outputs are registered; there is no combinational Start→output path.
- The Cost input is used only in the FETCH (k≥1) and ACC cycles.

## Structure
- Package jam_pkg holds:
  - the state enum (IDLE, FETCH, ACC, CMP, DONE);
  - the width helper functions: sum width, and a saturating increment.
- Sub-module jam_nextperm is parametrised on N and IDXW:
  - purely combinational;
  - inputs: the perm array;
  - outputs: the next perm array and last (no pivot).
- The top level holds the FSM, the FETCH counter, the accumulator, the min/count registers and the perm register array.

## Test plan
- **N=2, CW=7, table [[1,2],[3,4]], Start pulse:** Valid after 8 cycles, MinCost=5, MatchCount=2. The W/J sequence must be (0,0),(1,1),(0,1),(1,0).
- **N=8, all costs 1:** MinCost=8, MatchCount=40320, Valid at cycle 403200. Repeating the run with MCW=4 gives MatchCount=15 (saturated).
- **N=8, all costs 127:** MinCost=1016, MatchCount=40320. This checks there is no overflow of the 10-bit sum.
- **N=3, table [[5,9,9],[9,5,9],[9,9,1]]:** MinCost=11, MatchCount=1, Valid after 30 cycles. A Start pulse while Busy has no effect on timing or results.
- **Reset mid-run:** RST_n is asserted mid-FETCH on an N=4 run. All outputs go to their reset values immediately. A following Start produces a correct, full-length run.
- **Back-to-back runs:** Start is held high across two runs with the ROM changed between them. Valid pulses once per run, and the second run's results are independent of the first.
